// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: hazard/CP0/decode controls in, fetch address and status out.
interface pc_sequencer_if;
  logic        stall;
  logic        req;
  logic        eret_d;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        d_is_jump;
  logic [31:0] F_PC;
  logic        F_valid;
  logic        F_BD;
  logic        F_adel;
  logic        F_kill;
  logic        in_handler;

  modport master (
    output stall, req, eret_d, epc, br_valid, br_target, d_is_jump,
    input  F_PC, F_valid, F_BD, F_adel, F_kill, in_handler
  );

  modport slave (
    input  stall, req, eret_d, epc, br_valid, br_target, d_is_jump,
    output F_PC, F_valid, F_BD, F_adel, F_kill, in_handler
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter controller for the 5-stage MIPS pipeline:
// selects next PC (exception, ERET, stall, redirect, PC+4) and flags fetch faults.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  sif
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        bd_q, bd_d;

  // Misaligned or outside instruction memory, unsigned compares.
  function automatic logic fetch_addr_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    bd_d    = bd_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN, HANDLER: begin
        valid_d = 1'b1;
        if (sif.req) begin
          pc_d    = EXC_ENTRY;
          bd_d    = 1'b0;
          state_d = HANDLER;
        end else if (sif.eret_d && !sif.stall) begin
          pc_d    = sif.epc;
          bd_d    = 1'b0;
          state_d = RUN;
        end else if (sif.stall) begin
          // Hold PC, delay-slot flag and validity; a stalled ERET retries later.
          pc_d    = pc_q;
          bd_d    = bd_q;
          valid_d = valid_q;
        end else if (sif.br_valid) begin
          pc_d = sif.br_target;
          bd_d = sif.d_is_jump;
        end else begin
          pc_d = pc_q + 32'd4;
          bd_d = sif.d_is_jump;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
        pc_d    = RESET_PC;
        bd_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      bd_q    <= bd_d;
    end
  end

  // ERET has no delay slot, so the fetched instruction is squashed; req flushes via CP0 instead.
  assign sif.F_kill     = sif.eret_d & ~sif.stall & ~sif.req;
  assign sif.F_PC       = pc_q;
  assign sif.F_valid    = valid_q;
  assign sif.F_BD       = bd_q;
  assign sif.F_adel     = valid_q & fetch_addr_err(pc_q);
  assign sif.in_handler = (state_q == HANDLER);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage program-counter controller for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and chooses its next value each cycle. Sources, by priority: exception entry, ERET return, stall hold, D-stage branch/jump redirect, sequential PC+4.
- Tracks delay-slot status, fetch validity and exception-handler residency.
- Flags fetch address errors (AdEL) for CP0.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- stall  in  1  hazard unit freeze of the F and D stages.
- req  in  1  CP0 exception/interrupt request; takes effect this cycle.
- eret_d  in  1  ERET instruction in the D stage.
- epc  in  32  return address from CP0, used unmodified.
- br_valid  in  1  D-stage branch taken, or jump.
- br_target  in  32  D-stage redirect target.
- d_is_jump  in  1  D-stage instruction is any branch or jump, taken or not.
- F_PC  out  32  current fetch address; drives IM.
- F_valid  out  1  instruction in F is real (not a bubble).
- F_BD  out  1  instruction in F is a delay slot.
- F_adel  out  1  fetch address error on F_PC.
- F_kill  out  1  squash the instruction in F when it advances to D.
- in_handler  out  1  sequencer is between exception entry and ERET.

Behaviour:
- State machine states: BOOT, RUN, HANDLER. Reset enters BOOT.
- Reset values: F_PC=RESET_PC, F_valid=0, F_BD=0, in_handler=0. F_kill and F_adel follow the combinational rules below.
- BOOT: lasts exactly one cycle. F_valid=0. Next state is RUN with F_PC=RESET_PC unchanged and F_valid=1.
- Next-PC priority, evaluated in RUN and HANDLER:
  1. req: F_PC<=EXC_ENTRY, F_BD<=0, state<=HANDLER. Applies even when stall=1.
  2. eret_d & ~stall: F_PC<=epc, F_BD<=0, state<=RUN.
  3. stall: F_PC, F_BD and F_valid hold.
  4. br_valid: F_PC<=br_target, F_BD<=d_is_jump.
  5. Otherwise: F_PC<=F_PC+4 (wraps modulo 2^32), F_BD<=d_is_jump.
- eret_d with stall=1: nothing changes. The ERET retries in the next unstalled cycle.
- req and eret_d in the same cycle: req wins. State HANDLER is entered or kept.
- req while already in HANDLER: re-enter EXC_ENTRY and stay in HANDLER.
- F_kill = eret_d & ~stall & ~req, combinational. ERET has no delay slot, so the instruction in F is squashed.
- On req, F and younger stages are flushed by CP0. F_kill is not asserted for req.
- in_handler = (state==HANDLER).
- F_valid = 0 only in BOOT; otherwise 1. A stall holds the value.
- F_adel = F_valid & ((F_PC[1:0]!=0) | (F_PC<IM_BASE) | (F_PC>IM_LIMIT)), combinational, unsigned compares.
  - When F_adel=1, the PC still advances normally. CP0 raises req in a later cycle.
- Latency: a redirect input sampled at edge N is visible on F_PC after edge N, i.e. one cycle.
- Reset mid-operation (stall/req/branch active): reset dominates. All state returns to its reset value at that edge and BOOT is entered.
- No X propagation: epc and br_target are only sampled when selected.

Test Plan:
- Reset then 4 free-run cycles: F_PC 3000 (F_valid=0, BOOT), 3000, 3004, 3008, 300C; F_BD=0 throughout.
- At F_PC=3010 drive d_is_jump=1, br_valid=1, br_target=3100 → next F_PC=3100, F_BD=1. Next cycle with d_is_jump=0 → F_PC=3104, F_BD=0.
- stall=1 for 3 cycles at F_PC=3020 with br_valid=1 → F_PC, F_BD and F_valid hold at 3020. Release → F_PC=br_target.
- stall=1 and req=1 together at F_PC=3040 → next F_PC=4180, in_handler=1, F_BD=0. Also req with eret_d both 1 → 4180, F_kill=0.
- In HANDLER: eret_d=1, epc=3044, stall=0 → F_kill=1 that cycle; next F_PC=3044, in_handler=0. Repeat with stall=1 → no change until stall drops.
- br_target=3002 → F_adel=1. br_target=2FFC → F_adel=1. br_target=6FFC → F_adel=0. Then sequential step to 7000 → F_adel=1. Reset asserted during the stall → F_PC=3000, BOOT.
